// File: rtl/console_bus_writer.sv
// console_bus_writer
// Turns a character byte stream into word writes to a write-only text-mode
// screenbuffer. It tracks a cursor, writes printable bytes at the cursor and
// interprets CR, BS, LF and FF. Whole-screen and per-line clears are space
// fills. Scrolling is replaced by wrap-to-top with a clear of the new line.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/in_valid      character byte stream input
//   in_ready              byte accepted on an edge where in_valid && in_ready
//   addr/wdata/wmask/wen  registered bus write request, held until ack
//   ren                   constant 0 (the screenbuffer is never read)
//   ready                 bus acknowledge; completes a write when wen is high
//   busy                  high whenever the block is not idle
//   cursor_row/cursor_col current cursor position
module console_bus_writer #(
  parameter logic [31:0] SCREENBUFFER_BASE_ADDR = 32'h10000,
  parameter int unsigned COLS                   = 80,
  parameter int unsigned ROWS                   = 30,
  parameter bit          CLEAR_ON_RESET         = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic        wen,
  output logic        ren,
  input  logic        ready,
  output logic        busy,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);

  localparam int unsigned CNT_W       = 12;
  localparam int unsigned CLEAR_WORDS = ROWS * COLS / 4;
  localparam int unsigned LINE_WORDS  = COLS / 4;
  localparam logic [31:0] SPACES      = 32'h2020_2020;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    WRITE   = 2'd2,
    LINECLR = 2'd3
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [11:0]      idx;
  logic [31:0]      char_addr;
  logic [31:0]      clear_addr;
  logic [31:0]      line_addr;
  logic [4:0]       next_row;
  logic             last_col;

  // Handshake/status decoded straight from the state register.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign ren      = 1'b0;

  // Linear character index and the word addresses derived from it.
  assign idx        = 12'(32'(cursor_row) * COLS + 32'(cursor_col));
  assign char_addr  = SCREENBUFFER_BASE_ADDR + {20'd0, idx[11:2], 2'b00};
  assign clear_addr = SCREENBUFFER_BASE_ADDR + {18'd0, word_cnt, 2'b00};
  // COLS is a multiple of 4, so a row starts on a word boundary.
  assign line_addr  = SCREENBUFFER_BASE_ADDR + 32'(cursor_row) * COLS
                      + {18'd0, word_cnt, 2'b00};

  assign next_row = (cursor_row == 5'(ROWS - 1)) ? 5'd0 : cursor_row + 5'd1;
  assign last_col = (cursor_col == 7'(COLS - 1));

  // Cursor, bus request and fill-counter state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_STATE;
      word_cnt   <= '0;
      addr       <= '0;
      wdata      <= '0;
      wmask      <= '0;
      wen        <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      case (state)
        // Fill loops: present a word while wen is low, so every ack is
        // followed by exactly one idle bus cycle.
        CLEAR: begin
          if (!wen) begin
            wen   <= 1'b1;
            addr  <= clear_addr;
            wdata <= SPACES;
            wmask <= 4'hF;
          end else if (ready) begin
            wen <= 1'b0;
            if (word_cnt == CNT_W'(CLEAR_WORDS - 1)) begin
              word_cnt   <= '0;
              cursor_row <= '0;
              cursor_col <= '0;
              state      <= IDLE;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        LINECLR: begin
          if (!wen) begin
            wen   <= 1'b1;
            addr  <= line_addr;
            wdata <= SPACES;
            wmask <= 4'hF;
          end else if (ready) begin
            wen <= 1'b0;
            if (word_cnt == CNT_W'(LINE_WORDS - 1)) begin
              word_cnt <= '0;
              state    <= IDLE;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        IDLE: begin
          if (in_valid) begin
            case (in_data)
              CH_CR: cursor_col <= '0;
              CH_BS: begin
                if (cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
              end
              CH_LF: begin
                cursor_col <= '0;
                cursor_row <= next_row;
                word_cnt   <= '0;
                state      <= LINECLR;
              end
              CH_FF: begin
                cursor_col <= '0;
                cursor_row <= '0;
                word_cnt   <= '0;
                state      <= CLEAR;
              end
              default: begin
                // Byte replicated on all lanes; the mask selects the lane.
                addr  <= char_addr;
                wmask <= 4'b0001 << idx[1:0];
                wdata <= {4{in_data}};
                wen   <= 1'b1;
                state <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          if (ready) begin
            wen <= 1'b0;
            if (last_col) begin
              cursor_col <= '0;
              cursor_row <= next_row;
              word_cnt   <= '0;
              state      <= LINECLR;
            end else begin
              cursor_col <= cursor_col + 7'd1;
              state      <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_bus_writer.sv
// Bench for console_bus_writer: directed scenarios plus randomized byte
// streams checked against a screen/cursor model and a bus-write log.
module tb_console_bus_writer;

  localparam logic [31:0] BASE = 32'h10000;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int NCH  = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ren;
  logic        ready = 1'b0;
  logic        busy;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  console_bus_writer #(
    .SCREENBUFFER_BASE_ADDR(BASE),
    .COLS(COLS),
    .ROWS(ROWS),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
    .ready(ready), .busy(busy),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } txn_t;

  txn_t        log_q[$];
  logic [7:0]  ms[NCH];   // expected screen contents
  logic [7:0]  ds[NCH];   // screen as rebuilt from observed bus writes
  int          mrow, mcol;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat = 2;
  bit          hold = 1'b0;
  int          wcyc = 0;
  bit          prev_ack = 1'b0;
  bit          prev_wen = 1'b0;
  logic [67:0] prev_bus;
  int          gap_err = 0, stab_err = 0, range_err = 0;

  // Bus responder and monitor: ready after 'lat' wen cycles; log acks.
  always @(negedge clk) begin
    if (rst) begin
      wcyc = 0; ready = 1'b0; prev_ack = 1'b0; prev_wen = 1'b0;
    end else begin
      if (prev_ack && wen) gap_err++;
      if (prev_wen && !prev_ack && wen && ({addr, wdata, wmask} !== prev_bus))
        stab_err++;
      if (wen) wcyc++; else wcyc = 0;
      ready = !hold && wen && (wcyc >= lat);
      prev_ack = wen && ready;
      if (prev_ack) begin
        log_q.push_back('{a: addr, d: wdata, m: wmask});
        if (addr < BASE || ((addr - BASE) >> 2) >= NCH / 4 || addr[1:0] != 2'b00)
          range_err++;
        else
          for (int b = 0; b < 4; b++)
            if (wmask[b]) ds[int'((addr - BASE) >> 2) * 4 + b] = wdata[8*b +: 8];
      end
      prev_wen = wen;
      prev_bus = {addr, wdata, wmask};
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_fill_all();
    for (int i = 0; i < NCH; i++) ms[i] = 8'h20;
  endfunction

  function automatic void model_advance();
    mrow = (mrow + 1) % ROWS;
    for (int c = 0; c < COLS; c++) ms[mrow * COLS + c] = 8'h20;
  endfunction

  function automatic void model_apply(logic [7:0] ch);
    case (ch)
      8'h0D: mcol = 0;
      8'h08: if (mcol > 0) mcol--;
      8'h0A: begin mcol = 0; model_advance(); end
      8'h0C: begin mrow = 0; mcol = 0; model_fill_all(); end
      default: begin
        ms[mrow * COLS + mcol] = ch;
        mcol++;
        if (mcol == COLS) begin mcol = 0; model_advance(); end
      end
    endcase
  endfunction

  task automatic send(logic [7:0] ch);
    int n = 0;
    while (in_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) chk("send_timeout", 32'(in_ready), 32'd1);
    in_data  = ch;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_apply(ch);
  endtask

  task automatic wait_idle(string tag, int budget);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    if (busy !== 1'b0) chk({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_cursor(string tag);
    chk({tag, "_row"}, 32'(cursor_row), 32'(mrow));
    chk({tag, "_col"}, 32'(cursor_col), 32'(mcol));
  endtask

  task automatic chk_screen(string tag);
    int errs = 0;
    for (int i = 0; i < NCH; i++) if (ds[i] !== ms[i]) errs++;
    chk(tag, 32'(errs), 32'd0);
  endtask

  task automatic chk_fill(string tag, int first, logic [31:0] a0, int cnt);
    int errs = 0;
    for (int i = 0; i < cnt; i++)
      if (log_q.size() <= first + i || log_q[first + i].a !== a0 + 32'(4 * i) ||
          log_q[first + i].d !== 32'h2020_2020 || log_q[first + i].m !== 4'hF)
        errs++;
    chk(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    int n, cnt_hi;
    logic [7:0] ch;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < NCH; i++) ds[i] = 8'h00;

    // Reset values.
    #3;
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wmask", 32'(wmask), 32'd0);
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    model_fill_all(); mrow = 0; mcol = 0;

    // Power-on clear: 600 space words from BASE.
    wait_idle("clear", 5000);
    chk("clear_count", 32'(log_q.size()), 32'd600);
    chk_fill("clear_seq", 0, BASE, 600);
    chk("clear_in_ready", 32'(in_ready), 32'd1);
    chk("clear_busy", 32'(busy), 32'd0);
    chk_cursor("clear");
    chk_screen("clear_screen");

    // 'A' then 'B' at (0,0) share one word on different lanes.
    log_q.delete();
    send(8'h41);
    @(negedge clk);
    chk("acc_wen", 32'(wen), 32'd1);
    chk("acc_addr", addr, 32'h10000);
    wait_idle("a", 100);
    send(8'h42);
    wait_idle("b", 100);
    chk("ab_count", 32'(log_q.size()), 32'd2);
    chk("a_addr", log_q[0].a, 32'h10000);
    chk("a_mask", 32'(log_q[0].m), 32'h1);
    chk("a_data", log_q[0].d, 32'h41414141);
    chk("b_addr", log_q[1].a, 32'h10000);
    chk("b_mask", 32'(log_q[1].m), 32'h2);
    chk("b_data", log_q[1].d, 32'h42424242);
    chk_cursor("ab");

    // Last column wraps to the next row and clears it.
    send(8'h0D);
    for (int i = 0; i < 79; i++) begin send(8'h30 + 8'(i % 10)); wait_idle("fill79", 100); end
    chk("col79", 32'(cursor_col), 32'd79);
    log_q.delete();
    send(8'h5A);
    cnt_hi = 0; n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 500) begin
      if (in_ready !== 1'b0) cnt_hi++;
      @(negedge clk); n++;
    end
    chk("wrap_timeout", 32'(busy), 32'd0);
    chk("wrap_in_ready_hi", 32'(cnt_hi), 32'd0);
    chk("wrap_count", 32'(log_q.size()), 32'd21);
    chk("wrap_char_addr", log_q[0].a, 32'h1004C);
    chk("wrap_char_mask", 32'(log_q[0].m), 32'h8);
    chk("wrap_char_data", log_q[0].d, 32'h5A5A5A5A);
    chk_fill("wrap_line", 1, 32'h10050, 20);
    chk("wrap_row", 32'(cursor_row), 32'd1);
    chk("wrap_col", 32'(cursor_col), 32'd0);

    // LF on the bottom row wraps to row 0.
    for (int i = 0; i < 28; i++) begin send(8'h0A); wait_idle("lf", 200); end
    for (int i = 0; i < 5; i++) begin send(8'h61); wait_idle("c5", 100); end
    chk("pos29_row", 32'(cursor_row), 32'd29);
    chk("pos29_col", 32'(cursor_col), 32'd5);
    log_q.delete();
    send(8'h0A);
    wait_idle("lf29", 200);
    chk("lf29_count", 32'(log_q.size()), 32'd20);
    chk_fill("lf29_line", 0, 32'h10000, 20);
    chk("lf29_row", 32'(cursor_row), 32'd0);
    chk("lf29_col", 32'(cursor_col), 32'd0);

    // BS at column 0 does nothing; CR updates on the accept edge.
    for (int i = 0; i < 3; i++) begin send(8'h0A); wait_idle("lf3", 200); end
    log_q.delete();
    send(8'h08);
    cnt_hi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wen !== 1'b0) cnt_hi++;
    end
    chk("bs_wen", 32'(cnt_hi), 32'd0);
    chk("bs_count", 32'(log_q.size()), 32'd0);
    chk("bs_row", 32'(cursor_row), 32'd3);
    chk("bs_col", 32'(cursor_col), 32'd0);
    for (int i = 0; i < 7; i++) begin send(8'h62); wait_idle("c7", 100); end
    chk("pos37_col", 32'(cursor_col), 32'd7);
    send(8'h0D);
    chk("cr_col", 32'(cursor_col), 32'd0);
    chk("cr_in_ready", 32'(in_ready), 32'd1);
    cnt_hi = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) cnt_hi++;
    end
    chk("cr_in_ready_low", 32'(cnt_hi), 32'd0);
    chk_cursor("cr");

    // Randomized byte stream with varying bus latency.
    for (int k = 0; k < 250; k++) begin
      int r;
      lat = $urandom_range(1, 3);
      r = $urandom_range(0, 99);
      if (r < 5)       ch = 8'h0D;
      else if (r < 10) ch = 8'h08;
      else if (r < 20) ch = 8'h0A;
      else if (r < 70) ch = 8'($urandom_range(32, 126));
      else             ch = 8'($urandom_range(0, 255));
      send(ch);
      wait_idle("rand", 6000);
      chk_cursor("rand");
    end
    chk_screen("rand_screen");
    chk("gap_err", 32'(gap_err), 32'd0);
    chk("stab_err", 32'(stab_err), 32'd0);
    chk("range_err", 32'(range_err), 32'd0);
    lat = 2;

    // Reset during a stalled line clear.
    hold = 1'b1;
    send(8'h0A);
    n = 0;
    @(negedge clk);
    while (wen !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("lc_wen_seen", 32'(wen), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_wen", 32'(wen), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd1);
    chk("rst_async_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    model_fill_all(); mrow = 0; mcol = 0;
    repeat (2) @(negedge clk);
    hold = 1'b0;
    n = 0;
    while (log_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    chk("rerun_first_addr", log_q[0].a, 32'h10000);
    wait_idle("rerun", 5000);
    chk("rerun_count", 32'(log_q.size()), 32'd600);
    chk_fill("rerun_seq", 0, BASE, 600);
    chk_cursor("rerun");
    chk_screen("rerun_screen");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/console_bus_writer.md
# console_bus_writer

Bus initiator that turns a byte stream of characters into memory-mapped writes to the text-mode screenbuffer. It tracks a cursor, applies printable characters at the cursor position and interprets a small set of control codes. Whole-screen and per-line clears are performed with space fills. It sits between a byte source (UART RX, CPU FIFO) and the textmode GPU's bus port. The screenbuffer is write-only, so the block never reads and scrolling is replaced by wrap-to-top with line clear.

## Interface

- SCREENBUFFER_BASE_ADDR, 32'h10000, byte address of character (0,0).
- COLS, 80, characters per row; must be a multiple of 4.
- ROWS, 30, rows per screen.
- CLEAR_ON_RESET, 1, when 1 the block clears the full screen after reset; when 0 it goes straight to IDLE.
- clk  in  1  single clock; all logic is in this domain.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  8  character byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- addr  out  32  bus byte address, word-aligned.
- wdata  out  32  bus write data.
- wmask  out  4  bus byte-lane enables.
- wen  out  1  bus write request.
- ren  out  1  tied 0.
- ready  in  1  bus transaction done.
- busy  out  1  high when state is not IDLE.
- cursor_row  out  5  current row, 0..ROWS-1.
- cursor_col  out  7  current column, 0..COLS-1.

## Operation

- States: CLEAR, IDLE, WRITE, LINECLR.
- State after reset: CLEAR if CLEAR_ON_RESET, else IDLE.
- in_ready = (state == IDLE), decoded from the state register only.
- Accept: a byte is accepted on a rising edge where in_valid && in_ready.
- Character index idx = cursor_row*COLS + cursor_col, 12 bits.
- Char write addressing:
  - addr = BASE + {idx[11:2], 2'b00}
  - wmask = 4'b0001 << idx[1:0]
  - wdata = {4{in_data}}
- Accepted byte handling:
  - 0x0D (CR): cursor_col <= 0; stay IDLE; no bus activity.
  - 0x08 (BS): if cursor_col > 0, decrement cursor_col; stay IDLE; no bus write.
  - 0x0A (LF): cursor_col <= 0; row advance; go to LINECLR for the new row.
  - 0x0C (FF): cursor <= (0,0); go to CLEAR.
  - Any other byte: latch the char-write transaction; go to WRITE.
    - On acknowledge, cursor_col increments.
    - If the new column would equal COLS: cursor_col <= 0, row advance, go to LINECLR.
    - Otherwise return to IDLE.
- Row advance: cursor_row <= (cursor_row == ROWS-1) ? 0 : cursor_row + 1.
- LINECLR: COLS/4 word writes covering the new cursor row, in ascending address order; wmask 4'hF, wdata 32'h20202020. Then IDLE.
- CLEAR: ROWS*COLS/4 word writes from BASE in ascending order with the same data and mask. Then IDLE with cursor (0,0).
- Bus rule: addr, wdata and wmask are registered and held stable while wen is high.
- Acknowledge: a transaction completes on an edge where wen && ready. ready may already be high in the first wen cycle; that edge still counts.
- After every acknowledge, wen is low for at least one cycle.

## Timing

- Reset (async, immediate) values:
  - wen=0, addr=0, wdata=0, wmask=0, ren=0, cursor=(0,0).
  - in_ready=0 and busy=1 if CLEAR_ON_RESET; otherwise in_ready=1 and busy=0.
- Reset mid-transaction: wen drops with rst. After release the block re-enters the reset state, and any clear restarts from BASE.
- Accept edge: wen rises in the next cycle, with addr/wdata/wmask valid in that same cycle.
- Ack edge:
  - wen <= 0.
  - Cursor updates.
  - State changes; in_ready rises in the following cycle when returning to IDLE.
  - In CLEAR/LINECLR, the next word is presented one cycle after the ack.
- With the GPU responder (ready is 1 cycle after a new word address), a printable character costs 3 cycles from accept to next accept. It costs 2 cycles if the previous write hit the same word.
- CR and BS: the cursor updates on the accept edge; in_ready stays high.
- in_valid is ignored outside IDLE; in_data need not be held after accept.

## Test plan

- Reset with CLEAR_ON_RESET=1, ready responding 1 cycle after wen:
  - 600 writes, addr 0x10000..0x1095C step 4, wmask F, wdata 0x20202020.
  - Then in_ready=1, busy=0, cursor (0,0).
- At (0,0), send 0x41 then 0x42:
  - First write: addr 0x10000, wmask 0001, wdata 0x41414141.
  - Second write: addr 0x10000, wmask 0010, wdata 0x42424242.
  - Final cursor (0,2).
- At (0,79), send 0x5A:
  - Char write: addr 0x1004C, wmask 1000.
  - Then 20 writes 0x10050..0x1009C of 0x20202020.
  - Final cursor (1,0); in_ready low throughout.
- At (29,5), send 0x0A:
  - No char write.
  - 20 writes 0x10000..0x1004C.
  - Final cursor (0,0).
- At (3,0), send 0x08: no wen, cursor stays (3,0). Then at (3,7), send 0x0D: cursor becomes (3,0), in_ready never drops.
- Assert rst while wen is high mid-LINECLR and hold ready low for 5 cycles:
  - wen drops asynchronously with rst.
  - After release, CLEAR restarts at 0x10000.
